// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix-up at the end.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       MDOperation,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WriteHI,
   input  logic             WriteLO,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;     // product upper half / partial remainder
   logic [WIDTH-1:0] shreg;   // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] mcand;   // multiplicand / divisor magnitude
   logic [WIDTH-1:0] a_raw;
   logic             is_div, sa, sb;

   logic             signed_op, start_ok;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign Busy     = (state != IDLE);
   assign start_ok = Start && (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (Start) state_nx = RUN;
         RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      signed_op = ~MDOperation[0];
      a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
      b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
      mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, mcand} : '0);
      div_shift = {acc, shreg[WIDTH-1]};
      // Bit WIDTH of the trial set means the subtraction borrowed: restore.
      div_trial = div_shift - {1'b0, mcand};
      prod      = {acc, shreg};
      prod_fix  = (sa ^ sb) ? -prod : prod;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         shreg  <= '0;
         mcand  <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         Done   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         Done <= (state == FIX);
         if (state == IDLE) begin
            if (WriteHI) HI <= WriteData;
            if (WriteLO) LO <= WriteData;
         end
         case (state)
            IDLE: if (start_ok) begin
               cnt    <= '0;
               acc    <= '0;
               a_raw  <= A;
               is_div <= MDOperation[1];
               sa     <= signed_op & A[WIDTH-1];
               sb     <= signed_op & B[WIDTH-1];
               shreg  <= MDOperation[1] ? a_mag : b_mag;
               mcand  <= MDOperation[1] ? b_mag : a_mag;
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               if (is_div) begin
                  if (!div_trial[WIDTH]) begin
                     acc   <= div_trial[WIDTH-1:0];
                     shreg <= {shreg[WIDTH-2:0], 1'b1};
                  end else begin
                     acc   <= div_shift[WIDTH-1:0];
                     shreg <= {shreg[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc   <= mul_sum[WIDTH:1];
                  shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (is_div) begin
                  if (mcand == '0) begin
                     HI <= a_raw;
                     LO <= '1;
                  end else begin
                     HI <= sa ? -acc : acc;
                     LO <= (sa ^ sb) ? -shreg : shreg;
                  end
               end else begin
                  HI <= prod_fix[2*WIDTH-1:WIDTH];
                  LO <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
